// File: rtl/ppu_vram_port_ctrl_pkg.sv
// Shared definitions for the PPU VRAM port controller: CPU register indices,
// port FSM states and VRAM address increment steps.
package ppu_vram_port_ctrl_pkg;

  localparam logic [2:0] IDX_PPUADDR = 3'd6;
  localparam logic [2:0] IDX_PPUDATA = 3'd7;

  localparam logic [5:0] INC_1  = 6'd1;
  localparam logic [5:0] INC_32 = 6'd32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_BUS = 3'd1,
    ST_WRITE    = 3'd2,
    ST_READ     = 3'd3,
    ST_CAPTURE  = 3'd4,
    ST_INC      = 3'd5
  } state_t;

  function automatic logic [5:0] vram_inc(input logic inc32);
    return inc32 ? INC_32 : INC_1;
  endfunction

endpackage

// File: rtl/ppu_vram_addr_reg.sv
// PPUADDR latch: temporary address t, live address v and the shared write toggle w,
// plus the post-access increment of v.
module ppu_vram_addr_reg
  import ppu_vram_port_ctrl_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              addr_wr,
  input  logic              status_read,
  input  logic              inc_stb,
  input  logic              defer,
  input  logic [7:0]        din,
  input  logic              inc32,
  output logic [ADDR_W-1:0] v
);

  logic [ADDR_W-1:0] r_t;
  logic [ADDR_W-1:0] r_v;
  logic              r_w;
  logic              r_v_pend;
  logic [ADDR_W-1:0] w_t_next;
  logic              w_hi_wr;
  logic              w_lo_wr;

  // A status read on the same clock as a $2006 write discards the write.
  assign w_hi_wr = addr_wr && !status_read && !r_w;
  assign w_lo_wr = addr_wr && !status_read && r_w;

  always_comb begin
    w_t_next = r_t;
    if (w_hi_wr) w_t_next[ADDR_W-1:8] = din[ADDR_W-9:0];
    if (w_lo_wr) w_t_next[7:0] = din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_t      <= '0;
      r_v      <= '0;
      r_w      <= 1'b0;
      r_v_pend <= 1'b0;
    end else begin
      r_t <= w_t_next;
      if (status_read)  r_w <= 1'b0;
      else if (addr_wr) r_w <= ~r_w;

      // While an access is in flight v must stay put; a completed $2006 pair
      // replaces the increment when the access finishes.
      if (inc_stb) begin
        r_v      <= (r_v_pend || w_lo_wr) ? w_t_next : r_v + ADDR_W'(vram_inc(inc32));
        r_v_pend <= 1'b0;
      end else if (w_lo_wr) begin
        if (defer) r_v_pend <= 1'b1;
        else       r_v      <= w_t_next;
      end
    end
  end

  assign v = r_v;

endmodule

// File: rtl/ppu_vram_port_ctrl.sv
// PPUADDR/PPUDATA port controller: decodes CPU $2006/$2007 accesses and sequences
// buffered reads and single-cycle writes on the PPU memory interface.
module ppu_vram_port_ctrl
  import ppu_vram_port_ctrl_pkg::*;
#(
  parameter int READ_LAT = 2,
  parameter int ADDR_W   = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ph2_rising,
  input  logic              ph2_falling,
  input  logic              reg_sel,
  input  logic [2:0]        cpu_addr,
  input  logic              cpu_rnw,
  input  logic [7:0]        cpu_data_in,
  output logic [7:0]        cpu_data_out,
  input  logic              status_read,
  input  logic              ctrl_inc32,
  input  logic              render_active,
  output logic [ADDR_W-1:0] ppu_addr,
  output logic              ppu_wr_req,
  output logic [7:0]        ppu_din,
  input  logic [7:0]        ppu_dout,
  output logic              busy,
  output logic              overrun
);

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  state_t            r_state;
  logic              r_busy;
  logic              r_overrun;
  logic              r_is_rd;
  logic              r_wr_req;
  logic [7:0]        r_wdata;
  logic [7:0]        r_read_buf;
  logic [7:0]        r_cpu_data_out;
  logic [7:0]        r_ppu_din;
  logic [ADDR_W-1:0] r_ppu_addr;
  logic [CNT_W-1:0]  r_lat_cnt;

  logic [ADDR_W-1:0] w_v;
  logic              w_idx_data;
  logic              w_data_wr;
  logic              w_data_rd;
  logic              w_data_op;
  logic              w_addr_wr;
  logic              w_inc_stb;

  assign w_idx_data = reg_sel && (cpu_addr == IDX_PPUDATA);
  assign w_data_wr  = ph2_falling && w_idx_data && !cpu_rnw;
  assign w_data_rd  = ph2_rising && w_idx_data && cpu_rnw;
  assign w_data_op  = w_data_wr || w_data_rd;
  assign w_addr_wr  = ph2_falling && reg_sel && !cpu_rnw && (cpu_addr == IDX_PPUADDR);
  assign w_inc_stb  = (r_state == ST_INC);

  ppu_vram_addr_reg #(
    .ADDR_W (ADDR_W)
  ) u_addr_reg (
    .clk         (clk),
    .rst         (rst),
    .addr_wr     (w_addr_wr),
    .status_read (status_read),
    .inc_stb     (w_inc_stb),
    .defer       (r_busy),
    .din         (cpu_data_in),
    .inc32       (ctrl_inc32),
    .v           (w_v)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_busy         <= 1'b0;
      r_overrun      <= 1'b0;
      r_is_rd        <= 1'b0;
      r_wr_req       <= 1'b0;
      r_wdata        <= '0;
      r_read_buf     <= '0;
      r_cpu_data_out <= '0;
      r_ppu_din      <= '0;
      r_ppu_addr     <= '0;
      r_lat_cnt      <= '0;
    end else begin
      r_wr_req <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_data_op) begin
            r_state <= ST_WAIT_BUS;
            r_busy  <= 1'b1;
            r_is_rd <= w_data_rd;
            if (w_data_wr) r_wdata <= cpu_data_in;
          end
        end
        ST_WAIT_BUS: begin
          // The fetch engine owns the bus; address and strobes stay frozen.
          if (!render_active) begin
            r_ppu_addr <= w_v;
            if (r_is_rd) begin
              r_state   <= ST_READ;
              r_lat_cnt <= '0;
            end else begin
              r_state   <= ST_WRITE;
              r_wr_req  <= 1'b1;
              r_ppu_din <= r_wdata;
            end
          end
        end
        ST_WRITE: begin
          r_ppu_din <= '0;
          r_state   <= ST_INC;
        end
        ST_READ: begin
          if (r_lat_cnt == CNT_W'(READ_LAT - 1)) r_state <= ST_CAPTURE;
          else                                   r_lat_cnt <= r_lat_cnt + CNT_W'(1);
        end
        ST_CAPTURE: begin
          r_read_buf <= ppu_dout;
          r_state    <= ST_INC;
        end
        ST_INC: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      if (r_busy && w_data_op) r_overrun <= 1'b1;

      // Reads return the previously buffered byte; the new fetch refills the buffer.
      if (ph2_falling)                       r_cpu_data_out <= '0;
      else if (!r_busy && w_data_rd)         r_cpu_data_out <= r_read_buf;
    end
  end

  assign cpu_data_out = r_cpu_data_out;
  assign ppu_addr     = r_ppu_addr;
  assign ppu_wr_req   = r_wr_req;
  assign ppu_din      = r_ppu_din;
  assign busy         = r_busy;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_ppu_vram_port_ctrl.sv
// Randomized scoreboard bench for ppu_vram_port_ctrl against a PPUADDR/PPUDATA reference model.
module tb_ppu_vram_port_ctrl;

  localparam int ADDR_W = 14;
  localparam int MEM_SZ = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ph2_rising = 1'b0;
  logic        ph2_falling = 1'b0;
  logic        reg_sel = 1'b0;
  logic [2:0]  cpu_addr = 3'd0;
  logic        cpu_rnw = 1'b0;
  logic [7:0]  cpu_data_in = 8'd0;
  logic [7:0]  cpu_data_out;
  logic        status_read = 1'b0;
  logic        ctrl_inc32 = 1'b0;
  logic        render_active = 1'b0;
  logic [13:0] ppu_addr;
  logic        ppu_wr_req;
  logic [7:0]  ppu_din;
  logic [7:0]  ppu_dout = 8'd0;
  logic        busy;
  logic        overrun;

  ppu_vram_port_ctrl #(.READ_LAT(2), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .ph2_rising(ph2_rising), .ph2_falling(ph2_falling),
    .reg_sel(reg_sel), .cpu_addr(cpu_addr), .cpu_rnw(cpu_rnw), .cpu_data_in(cpu_data_in),
    .cpu_data_out(cpu_data_out), .status_read(status_read), .ctrl_inc32(ctrl_inc32),
    .render_active(render_active), .ppu_addr(ppu_addr), .ppu_wr_req(ppu_wr_req),
    .ppu_din(ppu_din), .ppu_dout(ppu_dout), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Memory manager model: two-clock read pipeline, contents seeded from a hash.
  logic [7:0] seed = 8'd0;
  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 37) + (a >> 7) + int'(seed));
  endfunction

  logic [7:0] mem [MEM_SZ];
  bit         mem_wr [MEM_SZ];
  logic [7:0] rd_d1 = 8'd0;
  always @(posedge clk) begin
    rd_d1    <= mem_wr[ppu_addr] ? mem[ppu_addr] : init_val(int'(ppu_addr));
    ppu_dout <= rd_d1;
    if (ppu_wr_req) begin
      mem[ppu_addr]    <= ppu_din;
      mem_wr[ppu_addr] <= 1'b1;
    end
  end

  // Reference model state
  logic [7:0]  ref_mem [MEM_SZ];
  int          m_t = 0;
  int          m_v = 0;
  bit          m_w = 0;
  logic [7:0]  m_buf = 8'd0;
  logic [21:0] wr_q[$];
  logic [7:0]  rd_q[$];

  // Monitors
  logic        rd_seen = 1'b0;
  logic        fall_seen = 1'b0;
  logic        ra_prev = 1'b0;
  logic [13:0] addr_prev = 14'd0;
  int          n_wr_seen = 0;
  logic [21:0] exp_w;
  logic [7:0]  exp_r;

  always @(posedge clk) begin
    rd_seen   <= ph2_rising && reg_sel && cpu_rnw && (cpu_addr == 3'd7);
    fall_seen <= ph2_falling;
  end

  always @(negedge clk) begin
    if (ppu_wr_req) begin
      n_wr_seen <= n_wr_seen + 1;
      chk("wr_expected", int'(wr_q.size() != 0), 1);
      if (wr_q.size() != 0) begin
        exp_w = wr_q.pop_front();
        chk("wr_addr", int'(ppu_addr), int'(exp_w[21:8]));
        chk("wr_data", int'(ppu_din), int'(exp_w[7:0]));
      end
    end
    if (rd_seen) begin
      chk("rd_expected", int'(rd_q.size() != 0), 1);
      if (rd_q.size() != 0) begin
        exp_r = rd_q.pop_front();
        chk("rd_data", int'(cpu_data_out), int'(exp_r));
      end
    end
    if (fall_seen) chk("dout_cleared", int'(cpu_data_out), 0);
    if (render_active && ra_prev) chk("addr_hold", int'(ppu_addr), int'(addr_prev));
    ra_prev   <= render_active;
    addr_prev <= ppu_addr;
  end

  // Bus-level stimulus
  task automatic cpu_wr(input logic [2:0] idx, input logic [7:0] d, input logic sel);
    @(posedge clk); #1;
    reg_sel = sel; cpu_addr = idx; cpu_rnw = 1'b0; cpu_data_in = d; ph2_falling = 1'b1;
    @(posedge clk); #1;
    ph2_falling = 1'b0; reg_sel = 1'b0;
  endtask

  task automatic cpu_rd();
    @(posedge clk); #1;
    reg_sel = 1'b1; cpu_addr = 3'd7; cpu_rnw = 1'b1; ph2_rising = 1'b1;
    @(posedge clk); #1;
    ph2_rising = 1'b0;
    @(posedge clk); #1;
    ph2_falling = 1'b1;
    @(posedge clk); #1;
    ph2_falling = 1'b0; reg_sel = 1'b0; cpu_rnw = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("busy_timeout", int'(busy), 0);
  endtask

  function automatic int step();
    return ctrl_inc32 ? 32 : 1;
  endfunction

  // Combined model + stimulus operations
  task automatic do_2006(input logic [7:0] d);
    if (!m_w) begin
      m_t = (m_t & 32'h00FF) | ((int'(d) & 32'h3F) << 8);
      m_w = 1;
    end else begin
      m_t = (m_t & 32'h3F00) | int'(d);
      m_v = m_t;
      m_w = 0;
    end
    cpu_wr(3'd6, d, 1'b1);
  endtask

  task automatic do_status();
    m_w = 0;
    @(posedge clk); #1 status_read = 1'b1;
    @(posedge clk); #1 status_read = 1'b0;
  endtask

  task automatic op_wr(input logic [7:0] d, input bit wt);
    logic [13:0] a;
    a = 14'(m_v);
    wr_q.push_back({a, d});
    ref_mem[m_v] = d;
    m_v = (m_v + step()) % MEM_SZ;
    cpu_wr(3'd7, d, 1'b1);
    if (wt) wait_idle();
  endtask

  task automatic op_rd(input bit wt);
    rd_q.push_back(m_buf);
    m_buf = ref_mem[m_v];
    m_v = (m_v + step()) % MEM_SZ;
    cpu_rd();
    if (wt) wait_idle();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    seed = 8'($urandom);
    for (int i = 0; i < MEM_SZ; i++) ref_mem[i] = init_val(i);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_data_out", int'(cpu_data_out), 0);
    chk("rst_ppu_addr", int'(ppu_addr), 0);
    chk("rst_wr_req", int'(ppu_wr_req), 0);
    chk("rst_ppu_din", int'(ppu_din), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst = 1'b0;

    // Plain write, then confirm the +1 increment through the next write
    ctrl_inc32 = 1'b0;
    do_2006(8'h21); do_2006(8'h00);
    op_wr(8'h5A, 1);
    op_wr(8'hC3, 1);

    // Buffered reads with +32 increment
    ctrl_inc32 = 1'b1;
    do_2006(8'h24); do_2006(8'h00);
    op_wr(8'h11, 1); op_wr(8'h22, 1);
    do_2006(8'h24); do_2006(8'h00);
    op_rd(1); op_rd(1); op_rd(1);
    op_wr(8'h77, 1);

    // Write stalled by the render engine
    ctrl_inc32 = 1'b0;
    do_2006(8'h20); do_2006(8'h00);
    render_active = 1'b1;
    op_wr(8'hA5, 0);
    repeat (5) begin
      @(negedge clk);
      chk("stall_busy", int'(busy), 1);
      chk("stall_no_wr", int'(ppu_wr_req), 0);
    end
    @(posedge clk); #1 render_active = 1'b0;
    @(negedge clk); chk("wr_not_early", int'(ppu_wr_req), 0);
    @(negedge clk); chk("wr_after_drop", int'(ppu_wr_req), 1);
    wait_idle();

    // Status read clears toggle; wrap cases
    do_2006(8'h3F); do_status(); do_2006(8'h20); do_2006(8'h05);
    op_wr(8'h01, 1);
    do_2006(8'h3F); do_2006(8'hFF);
    op_wr(8'h02, 1); op_wr(8'h03, 1);
    ctrl_inc32 = 1'b1;
    do_2006(8'h3F); do_2006(8'hF0);
    op_wr(8'h04, 1); op_wr(8'h05, 1);

    // Overrun: second $2007 write while the first is pending
    chk("overrun_clear", int'(overrun), 0);
    n0 = n_wr_seen;
    render_active = 1'b1;
    op_wr(8'hE1, 0);
    cpu_wr(3'd7, 8'hE2, 1'b1);
    #1 render_active = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    chk("overrun_set", int'(overrun), 1);
    chk("single_wr", n_wr_seen - n0, 1);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      ctrl_inc32 = 1'($urandom_range(0, 1));
      case (r)
        0, 1: begin do_2006(8'($urandom)); do_2006(8'($urandom)); end
        2, 3, 4: op_wr(8'($urandom), 1);
        5, 6, 7: op_rd(1);
        8: begin
          render_active = 1'b1;
          if ($urandom_range(0, 1) != 0) op_wr(8'($urandom), 0);
          else op_rd(0);
          do_2006(8'($urandom)); do_2006(8'($urandom));
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1 render_active = 1'b0;
          wait_idle();
        end
        default: begin
          if ($urandom_range(0, 2) == 0) do_status();
          else if ($urandom_range(0, 1) != 0) cpu_wr(3'd7, 8'($urandom), 1'b0);
          else cpu_wr(3'($urandom_range(0, 5)), 8'($urandom), 1'b1);
        end
      endcase
    end

    // Async reset in the middle of a read
    ctrl_inc32 = 1'b0;
    do_2006(8'h15); do_2006(8'h40);
    rd_q.push_back(m_buf);
    @(posedge clk); #1;
    reg_sel = 1'b1; cpu_addr = 3'd7; cpu_rnw = 1'b1; ph2_rising = 1'b1;
    @(posedge clk); #1;
    ph2_rising = 1'b0; reg_sel = 1'b0; cpu_rnw = 1'b0;
    @(posedge clk); #1;
    chk("busy_in_read", int'(busy), 1);
    chk("addr_in_read", int'(ppu_addr), 32'h1540);
    rst = 1'b1;
    #1;
    chk("arst_cpu_data_out", int'(cpu_data_out), 0);
    chk("arst_ppu_addr", int'(ppu_addr), 0);
    chk("arst_wr_req", int'(ppu_wr_req), 0);
    chk("arst_ppu_din", int'(ppu_din), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_overrun", int'(overrun), 0);
    @(posedge clk); #1 rst = 1'b0;
    m_t = 0; m_v = 0; m_w = 0; m_buf = 8'd0;

    do_2006(8'h12); do_2006(8'h34);
    op_rd(1); op_rd(1);
    op_wr(8'h9C, 1);

    repeat (5) @(negedge clk);
    chk("wr_q_drained", wr_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
